// File: rtl/hwpe_stream_word_packer_pkg.sv
// Shared types for the narrow-to-wide stream word packer.
// Holds the FSM encoding, control/flag bundles and a sizing helper.
package hwpe_stream_word_packer_pkg;

    localparam int unsigned PACKER_LEN_W = 32;

    typedef enum logic [1:0] {
        PACKER_IDLE  = 2'd0,
        PACKER_PACK  = 2'd1,
        PACKER_FLUSH = 2'd2
    } state_packer_t;

    typedef struct packed {
        logic                    start;
        logic [PACKER_LEN_W-1:0] len;
    } ctrl_packer_t;

    typedef struct packed {
        logic busy;
        logic done;
    } flags_packer_t;

    function automatic int unsigned packer_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with per-byte strobes.
// The sink accepts words, the source produces them.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    valid;
    logic                    ready;

    modport sink (
        input  data,
        input  strb,
        input  valid,
        output ready
    );

    modport source (
        output data,
        output strb,
        output valid,
        input  ready
    );
endinterface

// File: rtl/hwpe_stream_word_packer.sv
// Packs a length-bounded run of narrow stream words into wide beats,
// zero-padding the final partial beat and pulsing done when it drains.
module hwpe_stream_word_packer
    import hwpe_stream_word_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_IN  = 32,
    parameter int unsigned DATA_WIDTH_OUT = 128,
    parameter int unsigned NB_WORDS       = DATA_WIDTH_OUT / DATA_WIDTH_IN,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    hwpe_stream_intf_stream.sink   push_i,
    hwpe_stream_intf_stream.source pop_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned STRB_IN  = DATA_WIDTH_IN / 8;
    localparam int unsigned STRB_OUT = DATA_WIDTH_OUT / 8;
    localparam int unsigned IDX_W    = packer_idx_width(NB_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);

    if ((DATA_WIDTH_OUT % DATA_WIDTH_IN != 0) || (DATA_WIDTH_IN % 8 != 0)) begin : g_bad_width
        $error("hwpe_stream_word_packer: DATA_WIDTH_OUT must be a multiple of DATA_WIDTH_IN, which must be a multiple of 8");
    end

    typedef logic [NB_WORDS-1:0][DATA_WIDTH_IN-1:0] lanes_data_t;
    typedef logic [NB_WORDS-1:0][STRB_IN-1:0]       lanes_strb_t;

    state_packer_t           r_state;
    flags_packer_t           r_flags;
    ctrl_packer_t            w_ctrl;
    logic [CNT_WIDTH-1:0]    r_len_m1;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [IDX_W-1:0]        r_idx;
    lanes_data_t             r_lane_data;
    lanes_strb_t             r_lane_strb;
    lanes_data_t             w_beat_data;
    lanes_strb_t             w_beat_strb;
    logic                    r_complete;
    logic                    r_a_last;
    logic [DATA_WIDTH_OUT-1:0] r_o_data;
    logic [STRB_OUT-1:0]     r_o_strb;
    logic                    r_o_valid;
    logic                    w_push_ready;
    logic                    w_push_hs;
    logic                    w_pop_hs;
    logic                    w_o_free;
    logic                    w_last_word;
    logic                    w_close;

    assign w_ctrl.start = start_i;
    assign w_ctrl.len   = PACKER_LEN_W'(len_i);

    assign w_push_ready = (r_state == PACKER_PACK) && !r_complete;
    assign w_push_hs    = push_i.valid && w_push_ready;
    assign w_pop_hs     = r_o_valid && pop_o.ready;
    assign w_o_free     = !r_o_valid || pop_o.ready;
    assign w_last_word  = (r_cnt == r_len_m1);
    assign w_close      = w_push_hs && ((r_idx == LAST_IDX) || w_last_word);

    // Current assembly lanes with the incoming word merged at its slot,
    // so a closing word can go straight to the output register.
    always_comb begin
        w_beat_data = r_lane_data;
        w_beat_strb = r_lane_strb;
        for (int k = 0; k < NB_WORDS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_beat_data[k] = push_i.data;
                w_beat_strb[k] = push_i.strb;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state     <= PACKER_IDLE;
            r_flags     <= '0;
            r_len_m1    <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_lane_data <= '0;
            r_lane_strb <= '0;
            r_complete  <= 1'b0;
            r_a_last    <= 1'b0;
            r_o_data    <= '0;
            r_o_strb    <= '0;
            r_o_valid   <= 1'b0;
        end else begin
            r_flags.done <= 1'b0;
            if (w_pop_hs) begin
                r_o_valid <= 1'b0;
            end
            unique case (r_state)
                PACKER_IDLE: begin
                    if (w_ctrl.start) begin
                        if (w_ctrl.len != '0) begin
                            r_state      <= PACKER_PACK;
                            r_flags.busy <= 1'b1;
                            r_len_m1     <= w_ctrl.len[CNT_WIDTH-1:0] - CNT_WIDTH'(1);
                            r_cnt        <= '0;
                            r_idx        <= '0;
                        end else begin
                            r_flags.done <= 1'b1;
                        end
                    end
                end
                PACKER_PACK: begin
                    if (w_push_hs) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                        if (w_close && w_o_free) begin
                            r_o_data    <= w_beat_data;
                            r_o_strb    <= w_beat_strb;
                            r_o_valid   <= 1'b1;
                            r_lane_data <= '0;
                            r_lane_strb <= '0;
                            r_idx       <= '0;
                            if (w_last_word) begin
                                r_state <= PACKER_FLUSH;
                            end
                        end else if (w_close) begin
                            // Output still occupied: park the beat and stall the input.
                            r_lane_data <= w_beat_data;
                            r_lane_strb <= w_beat_strb;
                            r_complete  <= 1'b1;
                            r_a_last    <= w_last_word;
                        end else begin
                            r_lane_data <= w_beat_data;
                            r_lane_strb <= w_beat_strb;
                            r_idx       <= r_idx + IDX_W'(1);
                        end
                    end else if (r_complete && w_o_free) begin
                        r_o_data    <= r_lane_data;
                        r_o_strb    <= r_lane_strb;
                        r_o_valid   <= 1'b1;
                        r_lane_data <= '0;
                        r_lane_strb <= '0;
                        r_idx       <= '0;
                        r_complete  <= 1'b0;
                        r_a_last    <= 1'b0;
                        if (r_a_last) begin
                            r_state <= PACKER_FLUSH;
                        end
                    end
                end
                PACKER_FLUSH: begin
                    if (w_pop_hs) begin
                        r_state      <= PACKER_IDLE;
                        r_flags.busy <= 1'b0;
                        r_flags.done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= PACKER_IDLE;
                end
            endcase
        end
    end

    assign push_i.ready = w_push_ready;
    assign pop_o.data   = r_o_data;
    assign pop_o.strb   = r_o_strb;
    assign pop_o.valid  = r_o_valid;
    assign busy_o       = r_flags.busy;
    assign done_o       = r_flags.done;

endmodule

// File: tb/tb_hwpe_stream_word_packer.sv
// Directed bench for the word packer: a beat-level queue model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_hwpe_stream_word_packer;

    localparam int NBW = 4;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  strb;
        bit           last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] len_i = '0;
    logic        busy_o;
    logic        done_o;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32))  push ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(128)) pop ();

    hwpe_stream_word_packer #(
        .DATA_WIDTH_IN (32),
        .DATA_WIDTH_OUT(128),
        .CNT_WIDTH     (16)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .clear_i(clear_i),
        .start_i(start_i),
        .len_i  (len_i),
        .push_i (push),
        .pop_o  (pop),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    int           n_acc = 0;
    bit           model_on = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_hold = 1'b0;
    logic [127:0] h_data;
    logic [15:0]  h_strb;
    beat_t        exp_q[$];
    logic [127:0] obs_data[$];
    logic [15:0]  obs_strb[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Expected beats straight from the lane-order rule: word i goes to
    // beat i/4, lane i%4; missing lanes stay zero.
    task automatic plan(input int len, input logic [31:0] w[$], input logic [3:0] s[$]);
        int nb;
        nb = (len + NBW - 1) / NBW;
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e.data = '0;
            e.strb = '0;
            for (int k = 0; k < NBW; k++) begin
                int i;
                i = b * NBW + k;
                if (i < len) begin
                    e.data[k*32 +: 32] = w[i];
                    e.strb[k*4 +: 4]   = s[i];
                end
            end
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic compare_cycle();
        bit    nb;
        bit    nd;
        beat_t e;
        nb = m_busy;
        nd = 1'b0;
        chk("busy", busy_o, m_busy);
        chk("done", done_o, m_done);
        if (m_hold) begin
            chk("pop_hold_valid", pop.valid, 1);
            chk("pop_hold_data", pop.data, h_data);
            chk("pop_hold_strb", pop.strb, h_strb);
        end
        m_hold = 1'b0;
        if (exp_q.size() == 0) begin
            chk("pop_valid_unexpected", pop.valid, 0);
        end else if (pop.valid && pop.ready) begin
            e = exp_q.pop_front();
            chk("beat_data", pop.data, e.data);
            chk("beat_strb", pop.strb, e.strb);
            obs_data.push_back(pop.data);
            obs_strb.push_back(pop.strb);
            if (e.last) begin
                nb = 1'b0;
                nd = 1'b1;
            end
        end else if (pop.valid) begin
            m_hold = 1'b1;
            h_data = pop.data;
            h_strb = pop.strb;
        end
        if (!rst_ni || clear_i) begin
            exp_q.delete();
            nb     = 1'b0;
            nd     = 1'b0;
            m_hold = 1'b0;
        end else if (!m_busy && start_i) begin
            if (len_i == 0) nd = 1'b1;
            else nb = 1'b1;
        end
        m_busy = nb;
        m_done = nd;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) compare_cycle();
        end
    end

    task automatic push_word(input logic [31:0] d, input logic [3:0] s);
        push.data  = d;
        push.strb  = s;
        push.valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (push.ready) begin
                @(posedge clk);
                #1;
                push.valid = 1'b0;
                n_acc++;
                return;
            end
        end
        chk("push_ready_timeout", push.ready, 1);
        push.valid = 1'b0;
    endtask

    task automatic xfer(input int len, input logic [31:0] base, input bit vary, input int n_push);
        logic [31:0] w[$];
        logic [3:0]  s[$];
        for (int i = 0; i < len; i++) begin
            w.push_back(base + 32'(i) + 32'd1);
            s.push_back(vary ? 4'((i * 7 + 3) % 16) : 4'hF);
        end
        plan(len, w, s);
        n_acc   = 0;
        start_i = 1'b1;
        len_i   = 16'(len);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < n_push; i++) push_word(w[i], s[i]);
    endtask

    task automatic wait_done(input string nm);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                chk({nm, "_busy_at_done"}, busy_o, 0);
                @(posedge clk);
                #1;
                return;
            end
        end
        chk({nm, "_done_timeout"}, done_o, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        push.valid = 1'b0;
        push.data  = '0;
        push.strb  = '0;
        pop.ready  = 1'b1;
        idle(3);
        chk("rst_pop_valid", pop.valid, 0);
        chk("rst_pop_data", pop.data, 0);
        chk("rst_pop_strb", pop.strb, 0);
        chk("rst_push_ready", push.ready, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst_ni   = 1'b1;
        model_on = 1'b1;
        idle(2);

        // Two full beats, back to back.
        obs_data.delete();
        obs_strb.delete();
        xfer(8, 32'h0, 1'b0, 8);
        wait_done("t1");
        chk("t1_nbeats", obs_data.size(), 2);
        chk("t1_beat0", obs_data[0], 128'h00000004_00000003_00000002_00000001);
        chk("t1_beat1", obs_data[1], 128'h00000008_00000007_00000006_00000005);
        chk("t1_strb0", obs_strb[0], 16'hFFFF);
        chk("t1_strb1", obs_strb[1], 16'hFFFF);
        idle(2);

        // Zero-length transfer.
        start_i = 1'b1;
        len_i   = 16'd0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("t3_done", done_o, 1);
        chk("t3_busy", busy_o, 0);
        chk("t3_valid", pop.valid, 0);
        @(negedge clk);
        chk("t3_done_drop", done_o, 0);
        idle(2);

        // Partial final beat.
        obs_data.delete();
        obs_strb.delete();
        xfer(6, 32'h0, 1'b0, 6);
        chk("t2_flush_push_ready", push.ready, 0);
        chk("t2_flush_pop_valid", pop.valid, 1);
        wait_done("t2");
        chk("t2_nbeats", obs_data.size(), 2);
        chk("t2_beat1", obs_data[1], 128'h00000000_00000000_00000006_00000005);
        chk("t2_strb1", obs_strb[1], 16'h00FF);
        idle(2);

        // Backpressure: output stalls once the first beat shows up.
        obs_data.delete();
        obs_strb.delete();
        fork
            xfer(12, 32'h100, 1'b1, 12);
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk);
                    #1;
                    if (pop.valid) break;
                end
                pop.ready = 1'b0;
                repeat (9) @(posedge clk);
                #1;
                chk("t4_acc_stalled", n_acc, 8);
                chk("t4_push_ready_low", push.ready, 0);
                @(posedge clk);
                #1;
                pop.ready = 1'b1;
            end
        join
        wait_done("t4");
        chk("t4_nbeats", obs_data.size(), 3);
        chk("t4_beat2", obs_data[2], 128'h0000010C_0000010B_0000010A_00000109);
        chk("t4_strb2", obs_strb[2], 16'h092B);
        idle(2);

        // Soft clear mid-transfer, then a clean transfer.
        xfer(8, 32'h50, 1'b0, 3);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        chk("t5_valid", pop.valid, 0);
        chk("t5_busy", busy_o, 0);
        chk("t5_push_ready", push.ready, 0);
        obs_data.delete();
        obs_strb.delete();
        xfer(4, 32'h0, 1'b0, 4);
        wait_done("t5");
        chk("t5_nbeats", obs_data.size(), 1);
        chk("t5_beat0", obs_data[0], 128'h00000004_00000003_00000002_00000001);
        chk("t5_strb0", obs_strb[0], 16'hFFFF);
        idle(2);

        // Reset glitch between edges is ignored.
        obs_data.delete();
        obs_strb.delete();
        xfer(4, 32'h20, 1'b0, 2);
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_glitch_busy", busy_o, 1);
        chk("t6_glitch_ready", push.ready, 1);
        push_word(32'h23, 4'hF);
        push_word(32'h24, 4'hF);
        wait_done("t6");
        chk("t6_beat0", obs_data[0], 128'h00000024_00000023_00000022_00000021);
        idle(2);

        // Reset held across an edge mid-PACK.
        xfer(8, 32'h60, 1'b0, 2);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_valid", pop.valid, 0);
        chk("t6_rst_data", pop.data, 0);
        chk("t6_rst_strb", pop.strb, 0);
        chk("t6_rst_push_ready", push.ready, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_done", done_o, 0);
        rst_ni = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_word_packer.md
Name: hwpe_stream_word_packer

Overview:
Upstream feeder for the wide TCDM store sink. Packs a length-bounded sequence of narrow stream words into full-width beats, with per-byte strobes, and emits them on a wide stream. A final partial beat is zero-padded and carries partial strobes. It sits between a narrow datapath producer and the sink's incoming stream, and signals completion once the last beat has been consumed.

Parameters:
DATA_WIDTH_IN, 32, input word width in bits; must be a multiple of 8.
DATA_WIDTH_OUT, 128, output beat width in bits; must be a multiple of DATA_WIDTH_IN, otherwise elaboration fails.
NB_WORDS, DATA_WIDTH_OUT/DATA_WIDTH_IN, lanes per beat; derived, do not override.
CNT_WIDTH, 16, width of the transfer length counter.

Ports:
clk_i  in  1  clock, single clock domain
rst_ni  in  1  reset, synchronous, active-low
clear_i  in  1  synchronous soft clear, equivalent to reset
start_i  in  1  start a transfer; sampled only in IDLE
len_i  in  CNT_WIDTH  number of input words in the transfer; sampled with start_i
push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH_IN  narrow input stream (data, strb, valid, ready)
pop_o  hwpe_stream_intf_stream.source  DATA_WIDTH_OUT  wide output stream to the sink
busy_o  out  1  high while state != IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset and clear: rst_ni low at a clock edge forces every register to its reset value; rst_ni has priority over clear_i, which does the same.
- Reset values: state IDLE, pop valid/data/strb 0, push ready 0, busy_o 0, done_o 0, word and lane counters 0. Any in-progress beat is discarded.
- Registers:
  - Assembly register A: NB_WORDS lanes plus a complete flag.
  - Output register O: data, strb, valid; drives pop_o directly, with no combinational path from push to pop.
- State IDLE:
  - start_i with len_i != 0: latch len and go to PACK.
  - start_i with len_i == 0: stay IDLE and pulse done_o on the next cycle.
  - start_i outside IDLE is ignored.
- State PACK:
  - push ready = ~A.complete.
  - Each push handshake writes data and strb into lane[idx] of A, then increments idx and the word count.
  - The beat closes when idx == NB_WORDS-1 or the word count reaches len-1.
  - On the closing handshake, if O is empty or pop is handshaking in this cycle, A plus the incoming word load O at the edge, so pop valid rises 1 cycle after the final lane is accepted. A then clears: lanes 0, strb 0, idx 0.
  - Otherwise A.complete is set, push ready goes low, and A transfers to O on the first cycle O frees.
  - Unfilled lanes carry data 0 and strb 0. Input strb is copied bit-for-bit into its lane.
- Lane order: word k of a beat occupies bits [(k+1)*DATA_WIDTH_IN-1 : k*DATA_WIDTH_IN].
- Transition to FLUSH: when the final word of the transfer has been moved into O. In FLUSH push ready is 0.
- State FLUSH: on the pop handshake of the final beat, go to IDLE. done_o pulses in the cycle after that handshake.
- Pop handshake rules:
  - pop valid, once high, stays high with stable data and strb until ready.
  - O clears valid on handshake unless it reloads from A in the same cycle.
- Throughput: sustained 1 input word per cycle with pop ready held high.
- NB_WORDS == 1: plain registered pass-through with 1 cycle latency.
- The word counter does not wrap; len counts from 1 to 2^CNT_WIDTH-1.

Decomposition:
- The shared hwpe_stream package holds:
  - typedef state_packer_t, with states PACKER_IDLE, PACKER_PACK, PACKER_FLUSH;
  - typedef ctrl_packer_t, with fields start and len;
  - typedef flags_packer_t, with fields busy and done.
- No sub-module is needed. Lane write-enable decode stays inline.

Test Plan:
IN=32, OUT=128 unless stated otherwise.
1. len=8, words 0x1..0x8 back-to-back, pop ready=1 -> two beats, 0x00000004_00000003_00000002_00000001 then 0x8_7_6_5, strb 0xFFFF each; done_o pulses 1 cycle after the second pop handshake; busy_o falls on that same edge.
2. len=6 -> second beat data 0x00000000_00000000_00000006_00000005, strb 0x00FF; FLUSH is entered after word 6 is accepted.
3. start_i with len=0 -> no pop valid; done_o high exactly the cycle after start; busy_o stays 0.
4. len=12 with pop ready held 0 for 10 cycles after the first beat appears -> push ready drops after 8 words accepted (O full, A complete); when ready returns, all 3 beats arrive in order, no word lost or duplicated.
5. clear_i pulsed after 3 words of len=8 -> next cycle pop valid=0, busy_o=0, push ready=0; a following len=4 transfer yields the single beat 0x4_3_2_1 with strb 0xFFFF and no stale lanes.
6. rst_ni driven low between edges then released before the next edge -> no state change (synchronous reset). Held low across an edge mid-PACK -> all outputs at reset values after that edge.
